// File: rtl/distributor_pkg.sv
// Shared types for the 1-to-4 distributor: channel count, channel index and slot states.
package distributor_pkg;

    localparam int unsigned CH_NUM = 4;

    typedef logic [1:0] sel_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/dist_slot.sv
// One output channel of the distributor: a single data register plus its EMPTY/FULL
// state machine. A load always wins over a same-cycle drain, so a full slot refills bubble-free.
module dist_slot
    import distributor_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iData,
    input  logic             iDrain,
    output logic [WIDTH-1:0] oData,
    output logic             oValid
);

    slot_state_t      stateQ, stateD;
    logic [WIDTH-1:0] dataQ;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateD;
        end
    end

    // Draining leaves the register untouched; only a load or reset changes the data.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            dataQ <= '0;
        end else if (iLoad) begin
            dataQ <= iData;
        end
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            EMPTY: begin
                if (iLoad) begin
                    stateD = FULL;
                end
            end
            FULL: begin
                if (iDrain && !iLoad) begin
                    stateD = EMPTY;
                end
            end
            default: stateD = EMPTY;
        endcase
    end

    assign oData  = dataQ;
    assign oValid = (stateQ == FULL);

endmodule

// File: rtl/distributor_14.sv
// 1-to-4 data distributor with per-channel valid/ready and an accepted-word counter.
// Define AUTO_RR_EN to replace the iS1/iS0 select with an accept-driven round-robin pointer.
module distributor_14
    import distributor_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic [WIDTH-1:0] iData,
    input  logic             iValid,
    output logic             oReady,
    input  logic             iS1,
    input  logic             iS0,
    output logic [WIDTH-1:0] oZ0,
    output logic [WIDTH-1:0] oZ1,
    output logic [WIDTH-1:0] oZ2,
    output logic [WIDTH-1:0] oZ3,
    output logic [3:0]       oValid,
    input  logic [3:0]       iReady,
    output logic [CNT_W-1:0] oCount
);

    sel_t             sel;
    logic             accept;
    logic [3:0]       load;
    logic [WIDTH-1:0] slotData [CH_NUM];
    logic [CNT_W-1:0] countQ;

`ifdef AUTO_RR_EN
    sel_t rrPtrQ;
    logic unusedSel;

    assign unusedSel = iS1 ^ iS0;

    // The pointer only moves on accept, so a stalled channel holds the input rather than being skipped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rrPtrQ <= '0;
        end else if (accept) begin
            rrPtrQ <= rrPtrQ + 2'd1;
        end
    end

    assign sel = rrPtrQ;
`else
    assign sel = {iS1, iS0};
`endif

    assign oReady = ~oValid[sel] | iReady[sel];
    assign accept = iValid & oReady;

    always_comb begin
        load = '0;
        load[sel] = accept;
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : gSlot
        dist_slot #(
            .WIDTH (WIDTH)
        ) uSlot (
            .iClk   (iClk),
            .iRst   (iRst),
            .iLoad  (load[k]),
            .iData  (iData),
            .iDrain (iReady[k]),
            .oData  (slotData[k]),
            .oValid (oValid[k])
        );
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            countQ <= '0;
        end else if (accept) begin
            countQ <= countQ + 1'b1;
        end
    end

    assign oCount = countQ;
    assign oZ0    = slotData[0];
    assign oZ1    = slotData[1];
    assign oZ2    = slotData[2];
    assign oZ3    = slotData[3];

endmodule

// File: tb/tb_distributor_14.sv
// Self-checking bench for distributor_14: scoreboard of per-channel expected words plus
// directed checks. Round-robin scenarios are built when AUTO_RR_EN is defined.
module tb_distributor_14;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             iClk = 1'b0;
    logic             iRst = 1'b1;
    logic [WIDTH-1:0] iData = '0;
    logic             iValid = 1'b0;
    logic             oReady;
    logic             iS1 = 1'b0;
    logic             iS0 = 1'b0;
    logic [WIDTH-1:0] oZ0, oZ1, oZ2, oZ3;
    logic [3:0]       oValid;
    logic [3:0]       iReady = '0;
    logic [CNT_W-1:0] oCount;

    distributor_14 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iData  (iData),
        .iValid (iValid),
        .oReady (oReady),
        .iS1    (iS1),
        .iS0    (iS0),
        .oZ0    (oZ0),
        .oZ1    (oZ1),
        .oZ2    (oZ2),
        .oZ3    (oZ3),
        .oValid (oValid),
        .iReady (iReady),
        .oCount (oCount)
    );

    always #5 iClk = ~iClk;

    logic [WIDTH-1:0] zArr [4];
    assign zArr[0] = oZ0;
    assign zArr[1] = oZ1;
    assign zArr[2] = oZ2;
    assign zArr[3] = oZ3;

    int nChecks = 0;
    int nPass   = 0;

    logic [WIDTH-1:0] expQ [4][$];
    logic [WIDTH-1:0] modelZ [4];
    logic [CNT_W-1:0] modelCount = '0;
    logic [1:0]       modelPtr   = '0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Checks the cycle's handshake against the model, advances one clock, then checks state.
    task automatic tick();
        logic [1:0]       s;
        logic             rdy;
        logic [WIDTH-1:0] want;
        #1;
`ifdef AUTO_RR_EN
        s = modelPtr;
`else
        s = {iS1, iS0};
`endif
        rdy = (expQ[s].size() == 0) || iReady[s];
        checkVal("oReady", {31'b0, oReady}, {31'b0, rdy});
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("oValid[%0d]", k), {31'b0, oValid[k]},
                     {31'b0, expQ[k].size() != 0});
        end
        if (iRst) begin
            for (int k = 0; k < 4; k++) begin
                expQ[k].delete();
                modelZ[k] = '0;
            end
            modelCount = '0;
            modelPtr   = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (expQ[k].size() != 0 && iReady[k]) begin
                    want = expQ[k].pop_front();
                    checkVal($sformatf("deliver oZ%0d", k), {28'b0, zArr[k]}, {28'b0, want});
                end
            end
            if (iValid && rdy) begin
                expQ[s].push_back(iData);
                modelZ[s]  = iData;
                modelCount = modelCount + 1'b1;
                modelPtr   = modelPtr + 2'd1;
            end
        end
        @(posedge iClk);
        #1;
        checkVal("oCount", {24'b0, oCount}, {24'b0, modelCount});
        for (int k = 0; k < 4; k++) begin
            checkVal($sformatf("oZ%0d", k), {28'b0, zArr[k]}, {28'b0, modelZ[k]});
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [WIDTH-1:0] d,
                         input logic [1:0] s, input logic [3:0] rdy);
        iRst   = rst;
        iValid = v;
        iData  = d;
        {iS1, iS0} = s;
        iReady = rdy;
        tick();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) modelZ[k] = '0;

        // Reset held with iValid asserted.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 4'hF, 2'd1, 4'b0000);
        checkVal("reset oValid", {28'b0, oValid}, 32'h0);
        checkVal("reset oCount", {24'b0, oCount}, 32'h0);
        checkVal("reset oZ", {16'b0, oZ3, oZ2, oZ1, oZ0}, 32'h0);

`ifndef AUTO_RR_EN
        // Routing to channel 2.
        drive(1'b0, 1'b1, 4'hA, 2'd2, 4'b0000);
        checkVal("route oZ2", {28'b0, oZ2}, 32'hA);
        checkVal("route oValid", {28'b0, oValid}, 32'h4);
        checkVal("route oCount", {24'b0, oCount}, 32'h1);

        // Backpressure on channel 1, with sel wandering during the stall.
        drive(1'b0, 1'b1, 4'h5, 2'd1, 4'b0000);
        drive(1'b0, 1'b1, 4'h6, 2'd1, 4'b0000);
        checkVal("stall oCount", {24'b0, oCount}, 32'h2);
        drive(1'b0, 1'b1, 4'h7, 2'd2, 4'b0000);
        drive(1'b0, 1'b1, 4'h6, 2'd1, 4'b0000);
        iReady = 4'b0010;
        #1;
        checkVal("release oReady", {31'b0, oReady}, 32'h1);
        drive(1'b0, 1'b1, 4'h6, 2'd1, 4'b0010);
        checkVal("refill oValid1", {31'b0, oValid[1]}, 32'h1);
        checkVal("refill oZ1", {28'b0, oZ1}, 32'h6);

        // Streaming on channel 3 with a consumer that always drains.
        drive(1'b1, 1'b0, 4'h0, 2'd0, 4'b1111);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, WIDTH'(i), 2'd3, 4'b1000);
        drive(1'b0, 1'b0, 4'h0, 2'd3, 4'b1000);
        checkVal("stream oCount", {24'b0, oCount}, 32'h8);
        checkVal("stream oZ3", {28'b0, oZ3}, 32'h7);
`endif

        // Counter wrap after 2^CNT_W accepts.
        drive(1'b1, 1'b0, 4'h0, 2'd0, 4'b1111);
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, WIDTH'($urandom), 2'($urandom), 4'b1111);
        end
        checkVal("wrap oCount", {24'b0, oCount}, 32'h0);

        // Mid-operation reset while a full channel is being drained.
        drive(1'b0, 1'b1, 4'h9, 2'd0, 4'b0000);
        drive(1'b1, 1'b1, 4'h3, 2'd0, 4'b1111);
        checkVal("midreset oValid", {28'b0, oValid}, 32'h0);

        // Random traffic.
        drive(1'b0, 1'b0, 4'h0, 2'd0, 4'b0000);
        for (int i = 0; i < 400; i++) begin
            drive(1'b0, 1'($urandom), WIDTH'($urandom), 2'($urandom), 4'($urandom));
        end

`ifdef AUTO_RR_EN
        // Round robin with every consumer ready.
        drive(1'b1, 1'b0, 4'h0, 2'd0, 4'b1111);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 1'b1, WIDTH'(i), 2'd0, 4'b1111);
            checkVal("rr oValid", {28'b0, oValid}, 32'h1 << ((i - 1) % 4));
        end
        // Channel 2 stalled: the pointer waits there instead of skipping it.
        drive(1'b1, 1'b0, 4'h0, 2'd0, 4'b1111);
        for (int i = 1; i <= 8; i++) drive(1'b0, 1'b1, WIDTH'(i), 2'd0, 4'b1011);
        checkVal("rr stall oReady", {31'b0, oReady}, 32'h0);
        checkVal("rr stall oCount", {24'b0, oCount}, 32'h6);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
